// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_STABLE  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Width of a counter able to hold the largest of three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser plus stability filter for a bouncing level input.
// The output only takes a new level after DEB_CYC consecutive synced
// samples that differ from the current output.
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int DEB_CYC = 16,
  parameter int CW      = cnt_width(DEB_CYC, DEB_CYC, DEB_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic          meta_r;
  logic          sync_r;
  logic          dout_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw input and accept a new level once it has held long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      dout_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      if (sync_r != dout_r) begin
        if (cnt_r == CW'(DEB_CYC - 1)) begin
          dout_r <= sync_r;
          cnt_r  <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for a stable PLL lock and reset key, then releases
// the domain resets one by one. Lock loss drops every domain and is counted.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_LOCK     = 1,
  parameter int N_DOM      = 3,
  parameter int DEB_CYC    = 16,
  parameter int STABLE_CYC = 1024,
  parameter int STEP_CYC   = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_LOCK-1:0] lock_in,
  input  logic              ext_rst_n,
  input  logic              sw_rst_req,
  output logic [N_DOM-1:0]  dom_rst_n,
  output logic              all_ready,
  output logic [2:0]        state,
  output logic [7:0]        fault_cnt
);

  localparam int CW = cnt_width(DEB_CYC, STABLE_CYC, STEP_CYC);
  localparam int IW = $clog2(N_DOM + 1);

  logic [N_LOCK-1:0] lock_meta_r;
  logic [N_LOCK-1:0] lock_sync_r;
  logic              lock_ok_s;
  logic              ext_ok_s;
  logic              run_ok_s;

  state_t            state_r,  state_n_s;
  logic [CW-1:0]     cnt_r,    cnt_n_s;
  logic [IW-1:0]     idx_r,    idx_n_s;
  logic [N_DOM-1:0]  dom_r,    dom_n_s;
  logic [7:0]        fault_r,  fault_n_s;
  logic              ready_r,  ready_n_s;

  for (genvar g = 0; g < N_LOCK; g++) begin : g_lock_sync
    // Two-stage synchroniser for one asynchronous PLL lock flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        lock_meta_r[g] <= 1'b0;
        lock_sync_r[g] <= 1'b0;
      end else begin
        lock_meta_r[g] <= lock_in[g];
        lock_sync_r[g] <= lock_meta_r[g];
      end
    end
  end

  assign lock_ok_s = &lock_sync_r;

  rst_debounce #(
    .DEB_CYC (DEB_CYC),
    .CW      (CW)
  ) u_ext_deb (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .din  (ext_rst_n),
    .dout (ext_ok_s)
  );

  assign run_ok_s = lock_ok_s & ext_ok_s;

  // Next-state, counter, domain-mask and fault-count logic.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    idx_n_s   = idx_r;
    dom_n_s   = dom_r;
    fault_n_s = fault_r;
    case (state_r)
      ST_HOLD: begin
        dom_n_s = '0;
        cnt_n_s = '0;
        idx_n_s = '0;
        if (run_ok_s) begin
          state_n_s = ST_STABLE;
        end else begin
          state_n_s = ST_HOLD;
        end
      end
      ST_STABLE: begin
        if (!run_ok_s) begin
          state_n_s = ST_HOLD;
          cnt_n_s   = '0;
        end else if (cnt_r == CW'(STABLE_CYC - 1)) begin
          cnt_n_s    = '0;
          dom_n_s[0] = 1'b1;
          idx_n_s    = IW'(1);
          state_n_s  = (N_DOM == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_n_s = cnt_r + CW'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!lock_ok_s) begin
          // Lock loss outranks a key or software restart.
          state_n_s = ST_FAULT;
          dom_n_s   = '0;
          cnt_n_s   = '0;
          idx_n_s   = '0;
          fault_n_s = (fault_r == 8'd255) ? fault_r : fault_r + 8'd1;
        end else if (!ext_ok_s || sw_rst_req) begin
          state_n_s = ST_HOLD;
          dom_n_s   = '0;
          cnt_n_s   = '0;
          idx_n_s   = '0;
        end else if (state_r == ST_RUN) begin
          state_n_s = ST_RUN;
        end else if (cnt_r == CW'(STEP_CYC - 1)) begin
          cnt_n_s = '0;
          idx_n_s = idx_r + IW'(1);
          for (int i = 0; i < N_DOM; i++) begin
            if (idx_r == IW'(i)) begin
              dom_n_s[i] = 1'b1;
            end else begin
              dom_n_s[i] = dom_r[i];
            end
          end
          if (idx_r == IW'(N_DOM - 1)) begin
            state_n_s = ST_RUN;
          end else begin
            state_n_s = ST_RELEASE;
          end
        end else begin
          cnt_n_s = cnt_r + CW'(1);
        end
      end
      ST_FAULT: begin
        // Hold the domains down for a full step even if lock returns early.
        dom_n_s = '0;
        if (cnt_r == CW'(STEP_CYC - 1)) begin
          state_n_s = ST_HOLD;
          cnt_n_s   = '0;
        end else begin
          cnt_n_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_n_s = ST_HOLD;
        dom_n_s   = '0;
        cnt_n_s   = '0;
        idx_n_s   = '0;
      end
    endcase
    ready_n_s = (state_n_s == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= ST_HOLD;
      cnt_r   <= '0;
      idx_r   <= '0;
      dom_r   <= '0;
      fault_r <= 8'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      idx_r   <= idx_n_s;
      dom_r   <= dom_n_s;
      fault_r <= fault_n_s;
      ready_r <= ready_n_s;
    end
  end

  assign dom_rst_n = dom_r;
  assign all_ready = ready_r;
  assign state     = state_r;
  assign fault_cnt = fault_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with N_DOM=3, DEB=4, STABLE=8, STEP=4.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [0:0] lock_in;
  logic       ext_rst_n;
  logic       sw_rst_req;
  logic [2:0] dom_rst_n;
  logic       all_ready;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edges;
    logic       sw;
    logic [2:0] dom;
    logic       rdy;
    logic [2:0] st;
  } vec_t;

  vec_t seq_tbl[9];

  rst_seq_ctrl #(
    .N_LOCK     (1),
    .N_DOM      (3),
    .DEB_CYC    (4),
    .STABLE_CYC (8),
    .STEP_CYC   (4)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .lock_in    (lock_in),
    .ext_rst_n  (ext_rst_n),
    .sw_rst_req (sw_rst_req),
    .dom_rst_n  (dom_rst_n),
    .all_ready  (all_ready),
    .state      (state),
    .fault_cnt  (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [2:0] dom, input logic rdy, input logic [2:0] st);
    check({name, ".dom"},   32'(dom_rst_n), 32'(dom));
    check({name, ".ready"}, 32'(all_ready), 32'(rdy));
    check({name, ".state"}, 32'(state),     32'(st));
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int max_edges);
    int n;
    n = 0;
    while (state !== s && n < max_edges) begin
      tick(1);
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: timeout, state=%0d expected %0d", name, state, s);
    end
  endtask

  // From STABLE entry: walk the release table and check fault count at the end.
  task automatic run_seq(input string name, input logic [7:0] exp_fault);
    wait_state({name, ".stable"}, 3'd1, 40);
    for (int r = 0; r < 9; r++) begin
      sw_rst_req = seq_tbl[r].sw;
      tick(seq_tbl[r].edges);
      sw_rst_req = 1'b0;
      check_out($sformatf("%s.row%0d", name, r), seq_tbl[r].dom, seq_tbl[r].rdy, seq_tbl[r].st);
    end
    check({name, ".fault"}, 32'(fault_cnt), 32'(exp_fault));
  endtask

  initial begin
    // edges since previous row, sw pulse, expected dom, ready, state
    seq_tbl[0] = '{0, 1'b0, 3'b000, 1'b0, 3'd1};
    seq_tbl[1] = '{2, 1'b0, 3'b000, 1'b0, 3'd1};
    seq_tbl[2] = '{1, 1'b1, 3'b000, 1'b0, 3'd1};
    seq_tbl[3] = '{4, 1'b0, 3'b000, 1'b0, 3'd1};
    seq_tbl[4] = '{1, 1'b0, 3'b001, 1'b0, 3'd2};
    seq_tbl[5] = '{3, 1'b0, 3'b001, 1'b0, 3'd2};
    seq_tbl[6] = '{1, 1'b0, 3'b011, 1'b0, 3'd2};
    seq_tbl[7] = '{3, 1'b0, 3'b011, 1'b0, 3'd2};
    seq_tbl[8] = '{1, 1'b0, 3'b111, 1'b1, 3'd3};

    sys_rst    = 1'b1;
    lock_in    = 1'b1;
    ext_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
    tick(3);
    check_out("reset", 3'b000, 1'b0, 3'd0);
    check("reset.fault", 32'(fault_cnt), 32'd0);

    // Power-up sequence.
    sys_rst = 1'b0;
    run_seq("powerup", 8'd0);

    // Software restart from RUN, then a full re-sequence.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    check_out("sw_run", 3'b000, 1'b0, 3'd0);
    run_seq("sw_reseq", 8'd0);

    // Lock glitch of 3 cycles during STABLE: back to HOLD without a fault.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    wait_state("glitch.stable", 3'd1, 10);
    tick(3);
    lock_in = 1'b0;
    tick(3);
    check_out("glitch.hold", 3'b000, 1'b0, 3'd0);
    lock_in = 1'b1;
    check("glitch.fault", 32'(fault_cnt), 32'd0);
    run_seq("glitch_reseq", 8'd0);

    // Lock drop in RUN.
    lock_in = 1'b0;
    tick(2);
    check_out("lock_drop.e2", 3'b111, 1'b1, 3'd3);
    tick(1);
    check_out("lock_drop.e3", 3'b000, 1'b0, 3'd4);
    check("lock_drop.fault", 32'(fault_cnt), 32'd1);
    tick(3);
    check("fault_hold.last", 32'(state), 32'd4);
    tick(1);
    check("fault_exit", 32'(state), 32'd0);
    lock_in = 1'b1;
    run_seq("lock_reseq", 8'd1);

    // Short ext_rst_n bounces in RUN are filtered out.
    for (int i = 0; i < 3; i++) begin
      ext_rst_n = 1'b0;
      tick(1);
      ext_rst_n = 1'b1;
      tick(2);
    end
    tick(4);
    check_out("bounce", 3'b111, 1'b1, 3'd3);

    // A 4-cycle low is accepted: HOLD, no fault.
    ext_rst_n = 1'b0;
    tick(4);
    ext_rst_n = 1'b1;
    tick(2);
    check_out("ext_low.e6", 3'b111, 1'b1, 3'd3);
    tick(1);
    check_out("ext_low.e7", 3'b000, 1'b0, 3'd0);
    check("ext_low.fault", 32'(fault_cnt), 32'd1);

    // sw_rst_req in HOLD is ignored.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    check_out("sw_hold", 3'b000, 1'b0, 3'd0);
    run_seq("ext_reseq", 8'd1);

    // Repeated lock losses in RELEASE/RUN: fault counter saturates.
    for (int i = 0; i < 260; i++) begin
      lock_in = 1'b0;
      wait_state("sat.hold", 3'd0, 20);
      lock_in = 1'b1;
      wait_state("sat.release", 3'd2, 60);
      if (i == 99) begin
        check("sat.mid", 32'(fault_cnt), 32'd101);
      end
    end
    check("sat.final", 32'(fault_cnt), 32'd255);

    // Asynchronous reset mid-RELEASE.
    tick(1);
    check_out("pre_rst", 3'b001, 1'b0, 3'd2);
    sys_rst = 1'b1;
    #2;
    check_out("async_rst", 3'b000, 1'b0, 3'd0);
    check("async_rst.fault", 32'(fault_cnt), 32'd0);
    tick(2);
    sys_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset sequencer between the PLL(s) and the Qsys system plus its peripherals. It synchronises PLL lock flags and the external reset key, and requires a stable lock window before releasing N reset domains in a fixed order with a programmable gap. On lock loss it re-asserts every domain and counts the fault; it also accepts a software-requested restart.

## Interface
Parameters:
- N_LOCK, 1: number of PLL lock inputs; all must be high for lock_ok.
- N_DOM, 3: number of reset domains; bit 0 is released first.
- DEB_CYC, 16: consecutive stable cycles for a new ext_rst_n level to be accepted; ≥2.
- STABLE_CYC, 1024: cycles lock_ok & ext_ok must hold before the first release; ≥2.
- STEP_CYC, 256: cycles between consecutive domain releases; also the minimum FAULT hold; ≥2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - sys_clk, in, 1: system clock.
  - sys_rst, in, 1: asynchronous, active-high reset.
- lock_in, in, N_LOCK: PLL locked flags, asynchronous.
- ext_rst_n, in, 1: reset key, active-low, asynchronous, bouncing.
- sw_rst_req, in, 1: single-cycle restart request, synchronous to sys_clk.
- dom_rst_n, out, N_DOM: active-low domain resets, registered.
- all_ready, out, 1: high only in RUN.
- state, out, 3: current FSM state.
- fault_cnt, out, 8: lock-loss event count, saturating at 255.

## Operation
- Reset values: dom_rst_n=0, all_ready=0, state=HOLD, fault_cnt=0, ext_ok=0, counter=0, idx=0.
- lock_in[i] and ext_rst_n each pass through a 2-FF synchroniser.
- lock_ok is the AND of the synced lock bits.
- ext_ok is the debounced ext_rst_n. It takes a new level after DEB_CYC consecutive equal samples.
- State encoding: HOLD=0, STABLE=1, RELEASE=2, RUN=3, FAULT=4.
- HOLD
  - dom_rst_n all 0; counter cleared.
  - Goes to STABLE when lock_ok & ext_ok.
  - sw_rst_req is ignored.
- STABLE
  - Counter increments each cycle.
  - If lock_ok & ext_ok drops, go to HOLD; counter clears; no fault is counted.
  - At counter = STABLE_CYC-1, go to RELEASE; dom_rst_n[0] goes to 1 on the same edge; idx=1; counter clears.
  - sw_rst_req is ignored.
- RELEASE
  - Each time the counter reaches STEP_CYC-1, dom_rst_n[idx] goes to 1 and idx increments.
  - On the edge that sets dom_rst_n[N_DOM-1], go to RUN.
  - If N_DOM=1, STABLE goes directly to RUN.
- RUN: all_ready=1.
- Lock loss (lock_ok=0) in RELEASE or RUN
  - Go to FAULT; all dom_rst_n go to 0 on the next edge.
  - fault_cnt increments, saturating.
- ext_ok=0 or sw_rst_req=1 in RELEASE or RUN
  - Go to HOLD; all dom_rst_n go to 0 on the next edge; no fault is counted.
- Simultaneous lock loss and ext/sw request: lock loss wins; go to FAULT and count the fault.
- FAULT
  - Resets held for STEP_CYC cycles, then go to HOLD.
  - If lock returns early, STEP_CYC is still honoured.
- Counter width: $clog2(max(DEB_CYC, STABLE_CYC, STEP_CYC)+1). No other arithmetic.
- sys_rst asserted mid-sequence: all outputs return to reset values asynchronously, including fault_cnt.

## Timing
- Input-to-internal latency: 2 cycles (synchroniser); ext adds DEB_CYC.
- dom_rst_n[0] rises exactly STABLE_CYC edges after the edge that enters STABLE.
- dom_rst_n[k] rises k·STEP_CYC edges after dom_rst_n[0].
- all_ready rises on the same edge as dom_rst_n[N_DOM-1].
- Lock loss: dom_rst_n all low 3 edges after the lock_in falling edge (2 sync + 1 register).
- Reset assertion to the domains is never delayed further; de-assertion is always sequenced.

## Structure
- Package rst_seq_pkg: state enum with the fixed encoding, and a function for the counter width.
- Sub-module rst_debounce: 2-FF synchroniser plus DEB_CYC stability counter. Instantiated once for ext_rst_n.
- Lock synchronisation is a plain generate loop of 2-FF stages.

## Test plan
Common parameters: N_DOM=3, DEB_CYC=4, STABLE_CYC=8, STEP_CYC=4.
- Power-up: locks=1, ext=1, release sys_rst.
  - dom_rst_n steps 000→001→011→111, 4 edges apart.
  - dom0 rises 8 edges after STABLE entry; all_ready rises with 111.
- Lock glitch of 3 cycles during STABLE: back to HOLD, fault_cnt=0, counter restarts from 0.
- Lock drop in RUN:
  - dom_rst_n=000 within 3 edges; state=4 for 4 cycles, then HOLD.
  - fault_cnt=1; sequence re-runs when lock returns.
- ext_rst_n bounce (1-cycle lows) in RUN: no effect. A 4-cycle low gives HOLD with fault_cnt unchanged.
- sw_rst_req pulse in RUN: dom_rst_n=000 next edge, then full re-sequence; same pulse in HOLD is ignored.
- Force 260 lock losses: fault_cnt saturates at 255.
- sys_rst mid-RELEASE: outputs cleared asynchronously, including fault_cnt.
